// File: rtl/spin_sequencer.sv
// spin_sequencer: game-round controller between the raw start key and the
// payout logic. An accepted start press debits one credit, lets the three
// 2-bit reels follow the free-running counter, then stops them one at a time
// (A, B, C). Each reel stops after SPIN_CYCLES cycles. Once all three have
// stopped, a one-cycle result is issued with a win flag.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   clear         synchronous active-high reset
//   start_n       raw start key, active-low, asynchronous to clk
//   credit_ok     at least one credit available (sampled at the press)
//   rand_in[5:0]  free-running counter; [5:4] reel A, [3:2] reel B, [1:0] reel C
//   debit         one-cycle pulse: charge one credit
//   spinning      high while any reel is still spinning
//   reel_a/b/c    symbol shown on each reel
//   result_valid  one-cycle pulse: reels final, win valid
//   win           all three reels equal (only with result_valid)
module spin_sequencer #(
  parameter int unsigned SPIN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start_n,
  input  logic       credit_ok,
  input  logic [5:0] rand_in,
  output logic       debit,
  output logic       spinning,
  output logic [1:0] reel_a,
  output logic [1:0] reel_b,
  output logic [1:0] reel_c,
  output logic       result_valid,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE,
    SPIN_A,
    SPIN_B,
    SPIN_C,
    RESULT
  } state_e;

  localparam logic [7:0] RELOAD = 8'(SPIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] a_q, a_d;
  logic [1:0] b_q, b_d;
  logic [1:0] c_q, c_d;
  logic       debit_q, debit_d;
  logic       s1_q, s2_q, s3_q;
  logic       press;

  // Key released is the idle level, so the synchronizer chain clears to 1.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      debit_q <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      debit_q <= debit_d;
      s1_q    <= start_n;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  // Falling edge of the synchronized key: high for exactly one cycle.
  assign press = s3_q & ~s2_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    debit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press && credit_ok) begin
          state_d = SPIN_A;
          timer_d = RELOAD;
          debit_d = 1'b1;
        end
      end
      SPIN_A: begin
        if (timer_q == '0) begin
          a_d     = rand_in[5:4];
          timer_d = RELOAD;
          state_d = SPIN_B;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      SPIN_B: begin
        if (timer_q == '0) begin
          b_d     = rand_in[3:2];
          timer_d = RELOAD;
          state_d = SPIN_C;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      SPIN_C: begin
        if (timer_q == '0) begin
          c_d     = rand_in[1:0];
          timer_d = RELOAD;
          state_d = RESULT;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reel follows the counter until its own stop edge, then shows its latch.
  always_comb begin
    spinning = 1'b0;
    reel_a   = a_q;
    reel_b   = b_q;
    reel_c   = c_q;
    unique case (state_q)
      SPIN_A: begin
        spinning = 1'b1;
        reel_a   = rand_in[5:4];
        reel_b   = rand_in[3:2];
        reel_c   = rand_in[1:0];
      end
      SPIN_B: begin
        spinning = 1'b1;
        reel_b   = rand_in[3:2];
        reel_c   = rand_in[1:0];
      end
      SPIN_C: begin
        spinning = 1'b1;
        reel_c   = rand_in[1:0];
      end
      default: begin
        spinning = 1'b0;
      end
    endcase
  end

  assign debit        = debit_q;
  assign result_valid = (state_q == RESULT);
  assign win          = result_valid & (a_q == b_q) & (a_q == c_q);

endmodule
